// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and exception codes for the instruction-fetch stage.
// Also holds the fetch address legality check used by the stage.
package if_fetch_stage_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0000_6FFF;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // A fetch must be word aligned and the whole word must lie inside instruction memory.
    function automatic logic addrFault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IMEM_BASE) || (addr > (IMEM_LIMIT - 32'd3));
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Control and data bundle between the fetch stage and its surroundings
// (hazard unit, decode redirect, CP0, instruction memory, IF/ID register).
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] add4_f;
    logic [5:0]  opcode_f;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [25:0] imm26_f;
    logic        exc_f;
    logic [4:0]  exc_code_f;

    modport master (
        output stall, redirect_valid, redirect_target, exc_req, eret, epc, imem_rdata,
        input  imem_addr, pc_f, add4_f, opcode_f, rs_f, rt_f, rd_f, imm26_f, exc_f, exc_code_f
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, exc_req, eret, epc, imem_rdata,
        output imem_addr, pc_f, add4_f, opcode_f, rs_f, rt_f, rd_f, imm26_f, exc_f, exc_code_f
    );

endinterface

// File: rtl/if_fetch_stage_npc_sel.sv
// Next-PC priority selection plus the register that parks a branch/jump
// redirect which arrived while the pipeline was stalled.
module if_npc_sel
    import if_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    input  logic        i_exc_req,
    input  logic        i_eret,
    input  logic [31:0] i_epc,
    input  logic [31:0] i_pc,
    output logic [31:0] o_next_pc
);

    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    // Exceptions and ERET flush any parked redirect; a newer stalled redirect overwrites it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0;
        end else if (i_exc_req || i_eret) begin
            r_pend_valid  <= 1'b0;
        end else if (i_stall) begin
            if (i_redirect_valid) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= i_redirect_target;
            end
        end else begin
            r_pend_valid  <= 1'b0;
        end
    end

    // EPC is taken as-is so a misaligned return address faults in fetch.
    always_comb begin
        o_next_pc = i_pc + 32'd4;
        if (i_exc_req) begin
            o_next_pc = EXC_VECTOR;
        end else if (i_eret) begin
            o_next_pc = i_epc;
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end else if (i_redirect_valid) begin
            o_next_pc = i_redirect_target;
        end else if (r_pend_valid) begin
            o_next_pc = r_pend_target;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, checks the fetch address and
// slices the instruction word for the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    if_fetch_stage_if.slave  bus
);

    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_fault;

    if_npc_sel u_npc_sel (
        .clk               (clk),
        .reset             (reset),
        .i_stall           (bus.stall),
        .i_redirect_valid  (bus.redirect_valid),
        .i_redirect_target (bus.redirect_target),
        .i_exc_req         (bus.exc_req),
        .i_eret            (bus.eret),
        .i_epc             (bus.epc),
        .i_pc              (r_pc),
        .o_next_pc         (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign w_fault       = addrFault(r_pc);
    assign bus.imem_addr = r_pc;
    assign bus.pc_f      = r_pc;
    assign bus.add4_f    = r_pc + 32'd4;

    // A faulting fetch hands a NOP downstream along with the AdEL code.
    always_comb begin
        bus.exc_f      = 1'b0;
        bus.exc_code_f = EXC_INT;
        bus.opcode_f   = bus.imem_rdata[31:26];
        bus.rs_f       = bus.imem_rdata[25:21];
        bus.rt_f       = bus.imem_rdata[20:16];
        bus.rd_f       = bus.imem_rdata[15:11];
        bus.imm26_f    = bus.imem_rdata[25:0];
        if (w_fault) begin
            bus.exc_f      = 1'b1;
            bus.exc_code_f = EXC_ADEL;
            bus.opcode_f   = 6'd0;
            bus.rs_f       = 5'd0;
            bus.rt_f       = 5'd0;
            bus.rd_f       = 5'd0;
            bus.imm26_f    = 26'd0;
        end
    end

endmodule
